// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for one shared, possibly
// multi-cycle ALU. A request is accepted and latched, held on the ALU until
// alu_We or a timeout, and then presented as a response to its owner.
// Ports:
//   Clk, Reset                  clock, synchronous active-low reset
//   reqN_valid/_A/_B/_op        request from requester N (0/1)
//   reqN_ready                  request accepted this cycle (combinational)
//   rspN_valid, rspN_ready      response handshake per requester
//   rsp_result, rsp_c, rsp_err  shared response payload
//   alu_A, alu_B, alu_ALUOp     operands/opcode to the ALU
//   alu_Result, alu_C, alu_We   result, carry and result-valid from the ALU
//   busy                        FSM is not in IDLE
module alu_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic [31:0] req0_A,
  input  logic [31:0] req0_B,
  input  logic [31:0] req1_A,
  input  logic [31:0] req1_B,
  input  logic [2:0]  req0_op,
  input  logic [2:0]  req1_op,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_c,
  output logic        rsp_err,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [2:0]  alu_ALUOp,
  input  logic [31:0] alu_Result,
  input  logic        alu_C,
  input  logic        alu_We,
  output logic        busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              id_q, id_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              c_q, c_d;
  logic              err_q, err_d;
  logic              gnt0, gnt1;

  // State and datapath registers; reset forgets any in-flight operation.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      id_q    <= 1'b0;
      last_q  <= 1'b1;  // requester 0 wins the first tie
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      c_q     <= c_d;
      err_q   <= err_d;
    end
  end

  // Next-state, grant and output decode. Handshake outputs are masked
  // while Reset is asserted so nothing is offered during reset.
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    last_d     = last_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    c_d        = c_q;
    err_d      = err_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    alu_A      = '0;
    alu_B      = '0;
    alu_ALUOp  = '0;
    busy       = 1'b0;

    // Round-robin: on a tie, serve whoever was not served last.
    gnt0 = req0_valid && (!req1_valid || last_q);
    gnt1 = req1_valid && (!req0_valid || !last_q);

    case (state_q)
      S_IDLE: begin
        req0_ready = Reset && gnt0;
        req1_ready = Reset && gnt1;
        if (gnt0 || gnt1) begin
          id_d    = gnt1;
          a_d     = gnt1 ? req1_A  : req0_A;
          b_d     = gnt1 ? req1_B  : req0_B;
          op_d    = gnt1 ? req1_op : req0_op;
          cnt_d   = '0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        busy = Reset;
        if (Reset) begin
          alu_A     = a_q;
          alu_B     = b_q;
          alu_ALUOp = op_q;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (alu_We) begin
          res_d   = alu_Result;
          c_d     = alu_C;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          res_d   = '0;
          c_d     = 1'b0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        busy       = Reset;
        rsp0_valid = Reset && !id_q;
        rsp1_valid = Reset && id_q;
        if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
          last_d  = id_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rsp_result = res_q;
  assign rsp_c      = c_q;
  assign rsp_err    = err_q;

endmodule
